// File: rtl/ts_bus_master.sv
// Half-duplex master for a tristate bus: sequences per-lane output enables through
// DRIVE -> TA for writes and WAIT -> sample for reads, one request at a time.

module ts_bus_lane (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clr,
  input  logic d,
  input  logic m,
  output logic oe,
  output logic q
);
  always_ff @(posedge clk) begin
    if (reset) begin
      oe <= 1'b0;
      q  <= 1'b0;
    end else if (load) begin
      oe <= m;
      q  <= d;
    end else if (clr) begin
      oe <= 1'b0;
    end
  end
endmodule

module ts_bus_master #(
  parameter int WIDTH        = 2,
  parameter int DRIVE_CYCLES = 1,
  parameter int TA_CYCLES    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] bus_oe,
  output logic             busy,
  inout  wire  [WIDTH-1:0] bus
);
  localparam int MAXC = (DRIVE_CYCLES > TA_CYCLES) ? DRIVE_CYCLES : TA_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] D_LD = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] T_LD = CW'(TA_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TA, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             cnt_zero, accept, drive_end, rd_done;
  logic [WIDTH-1:0] data_q;

  assign cnt_zero  = (cnt == '0);
  assign drive_end = (state == S_DRIVE) && cnt_zero;
  assign rd_done   = (state == S_WAIT) && cnt_zero;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = req_write ? S_DRIVE : S_WAIT;
      S_DRIVE: if (cnt_zero) state_nxt = S_TA;
      S_TA:    if (cnt_zero) state_nxt = S_IDLE;
      S_WAIT:  if (cnt_zero) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE) && !reset;
    busy      = (state != S_IDLE);
    accept    = req_valid && req_ready;
  end

  // One counter serves every timed phase; it reloads with the TA length as DRIVE ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE:  if (accept) cnt <= req_write ? D_LD : T_LD;
        S_DRIVE: cnt <= cnt_zero ? T_LD : cnt - CW'(1);
        default: cnt <= cnt_zero ? '0 : cnt - CW'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rd_done;
      if (rd_done) rsp_data <= bus;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ts_bus_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (accept && req_write),
      .clr   (drive_end),
      .d     (req_data[i]),
      .m     (req_mask[i]),
      .oe    (bus_oe[i]),
      .q     (data_q[i])
    );
    assign bus[i] = bus_oe[i] ? data_q[i] : 1'bz;
  end
endmodule

// File: tb/tb_ts_bus_master.sv
// Randomized bench for ts_bus_master: a cycle-indexed schedule model predicts enables,
// drive values and read responses; a negedge monitor checks against it.

module tb_ts_bus_master;
  localparam int W = 4;
  localparam int D = 3;
  localparam int T = 2;
  localparam int NC = 4096;

  logic         clk;
  logic         reset;
  logic         req_valid, req_ready, req_write;
  logic [W-1:0] req_data, req_mask;
  logic         rsp_valid, busy;
  logic [W-1:0] rsp_data, bus_oe;
  wire  [W-1:0] bus;
  logic [W-1:0] tb_oe, tb_val;

  for (genvar i = 0; i < W; i++) begin : g_far
    assign bus[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  ts_bus_master #(.WIDTH(W), .DRIVE_CYCLES(D), .TA_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .bus_oe(bus_oe), .busy(busy), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference schedule, indexed by cycle number.
  typedef struct { int cyc; logic [W-1:0] d; } rsp_t;
  rsp_t         rq[$];
  logic [W-1:0] exp_oe [NC];
  logic [W-1:0] exp_dat[NC];
  bit           rd_en  [NC];
  logic [W-1:0] rd_val [NC];
  logic [W-1:0] rsp_last, v;
  int           c, free_at, last_acc;
  bit           acc, exp_busy;
  int           n_cmp, n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  always @(posedge clk) begin
    c = c + 1;
    #1;
    tb_oe  = rd_en[c] ? '1 : '0;
    tb_val = rd_val[c];
  end

  always @(negedge clk) begin
    if (c >= 1) begin
      exp_busy = (c < free_at);
      chk("req_ready", 32'(req_ready), 32'(!reset && !exp_busy));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("bus_oe", 32'(bus_oe), 32'(exp_oe[c]));
      if (exp_oe[c] != '0) chk("bus_drive", 32'(bus & exp_oe[c]), 32'(exp_dat[c] & exp_oe[c]));
      if (rd_en[c]) chk("bus_read_window", 32'(bus), 32'(rd_val[c]));
      if (rsp_valid) begin
        if (rq.size() == 0) chk("rsp_spurious", 32'(rsp_valid), 32'd0);
        else begin
          chk("rsp_cycle", 32'(c), 32'(rq[0].cyc));
          chk("rsp_data_new", 32'(rsp_data), 32'(rq[0].d));
          rsp_last = rq[0].d;
          void'(rq.pop_front());
        end
      end else if (rq.size() != 0 && rq[0].cyc <= c) begin
        chk("rsp_missing", 32'(rsp_valid), 32'd1);
        void'(rq.pop_front());
      end
      chk("rsp_data_hold", 32'(rsp_data), 32'(rsp_last));
      // advance model for the edge ending this cycle
      acc = 1'b0;
      if (reset) begin
        for (int k = 1; k <= 16; k++) begin
          exp_oe[c+k] = '0;
          rd_en[c+k]  = 1'b0;
        end
        rq.delete();
        rsp_last = '0;
        free_at  = c + 1;
      end else if (req_valid && !exp_busy) begin
        acc = 1'b1;
        last_acc = c;
        if (req_write) begin
          for (int k = 1; k <= D; k++) begin
            exp_oe[c+k]  = req_mask;
            exp_dat[c+k] = req_data;
          end
          free_at = c + 1 + D + T;
        end else begin
          v = W'($urandom);
          for (int k = 1; k <= T; k++) begin
            rd_en[c+k]  = 1'b1;
            rd_val[c+k] = v;
          end
          rq.push_back('{c + 1 + T, v});
          free_at = c + 1 + T;
        end
      end
    end
  end

  task automatic send(input bit w, input logic [W-1:0] d, input logic [W-1:0] m);
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = w; req_data = d; req_mask = m;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk); #1;
      if (acc) return;
    end
    chk("handshake_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic rst_pulse();
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
  endtask

  initial begin
    int a1;
    n_cmp = 0; n_bad = 0; c = 0; free_at = 0; last_acc = 0; acc = 1'b0;
    rsp_last = '0; tb_oe = '0; tb_val = '0;
    for (int k = 0; k < NC; k++) begin
      exp_oe[k] = '0; exp_dat[k] = '0; rd_en[k] = 1'b0; rd_val[k] = '0;
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_data = '0; req_mask = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    send(1'b1, 4'b1111, 4'b1111);
    send(1'b1, 4'b0101, 4'b0101);
    send(1'b0, 4'b0000, 4'b1111);
    send(1'b1, 4'b1010, 4'b0000);
    idle(2);
    // back-to-back write then read with req_valid held high
    send(1'b1, 4'b0011, 4'b0011);
    a1 = last_acc;
    send(1'b0, 4'b0000, 4'b0000);
    chk("b2b_spacing", 32'(last_acc - a1), 32'(1 + D + T));
    a1 = last_acc;
    send(1'b0, 4'b0000, 4'b0000);
    chk("rd_spacing", 32'(last_acc - a1), 32'(1 + T));
    idle(8);

    // reset in the second DRIVE cycle of a write
    send(1'b1, 4'b1111, 4'b1111);
    a1 = last_acc;
    @(posedge clk); #2 req_valid = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    send(1'b0, 4'b0000, 4'b0000);
    chk("post_reset_accept", 32'(last_acc - a1), 32'd4);
    idle(6);

    for (int n = 0; n < 80; n++) begin
      send(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) begin
        idle($urandom_range(0, 3));
        rst_pulse();
      end
    end
    idle(12);
    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
